// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED pattern arbiter: state encoding, counter
// width derivation and the round-robin requester select.
package led_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StGap  = 2'd2
    } state_e;

    // Upper bound on requesters; the select function works on a vector this wide.
    localparam int unsigned MaxReq  = 8;
    localparam int unsigned MaxReqW = 3;

    // Counter/index width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [MaxReqW-1:0] rr_select(
        input logic [MaxReq-1:0]  req,
        input logic [MaxReqW-1:0] ptr,
        input int unsigned        n
    );
        logic [MaxReqW-1:0] sel;
        logic [MaxReqW-1:0] idx_w;
        logic               found;
        int unsigned        base;
        int unsigned        idx;
        sel   = '0;
        found = 1'b0;
        base  = 32'(ptr);
        for (int unsigned i = 0; i < MaxReq; i++) begin
            idx   = (base + i) % n;
            idx_w = idx[MaxReqW-1:0];
            if (!found && (i < n) && req[idx_w]) begin
                sel   = idx_w;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-period counter: counts 0..STEP_DIV-1 and flags the terminal count.
// Synchronous clear holds it at zero while idle.
module step_prescaler
    import led_arb_pkg::*;
#(
    parameter int unsigned STEP_DIV = 2097152
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CntW    = cnt_width(STEP_DIV);
    localparam logic [CntW-1:0] TermCnt = CntW'(STEP_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TermCnt);

    // Wrap on the terminal count so non-power-of-two dividers are exact.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Round-robin owner of the single user LED: grants one status source at a time,
// plays its latched pattern LSB-first at one bit per step, then holds a gap.
module led_pattern_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned PAT_W      = 32,
    parameter int unsigned STEP_DIV   = 2097152,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PAT_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     LED
);

    localparam int unsigned     ReqW    = cnt_width(NUM_REQ);
    localparam int unsigned     IdxW    = cnt_width(PAT_W);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PAT_W - 1);
    localparam logic [ReqW-1:0] LastReq = ReqW'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 led_q, led_d;
    logic [PAT_W-1:0]     pat_q, pat_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [ReqW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ReqW-1:0]      sel_q, sel_d;

    logic [MaxReq-1:0]    req_ext;
    logic [MaxReqW-1:0]   ptr_ext;
    logic [MaxReqW-1:0]   sel_ext;
    logic [ReqW-1:0]      rr_sel;
    logic                 step_clr;
    logic                 step_tick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        ptr_ext                = '0;
        ptr_ext[ReqW-1:0]      = rr_ptr_q;
    end

    assign sel_ext = rr_select(req_ext, ptr_ext, NUM_REQ);
    assign rr_sel  = sel_ext[ReqW-1:0];

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_step (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (step_clr),
        .tick (step_tick)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        led_d     = led_q;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        rr_ptr_d  = rr_ptr_q;
        sel_d     = sel_q;
        step_clr  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Prescaler parked at zero so the first bit gets a full step.
                step_clr = 1'b1;
                led_d    = IDLE_LEVEL;
                if (|req) begin
                    sel_d         = rr_sel;
                    gnt_d         = '0;
                    gnt_d[rr_sel] = 1'b1;
                    pat_d         = pattern[rr_sel*PAT_W +: PAT_W];
                    bit_idx_d     = '0;
                    led_d         = pat_d[0];
                    state_d       = StPlay;
                end
            end
            StPlay: begin
                if (step_tick) begin
                    if (bit_idx_q == LastIdx) begin
                        done_d   = gnt_q;
                        gnt_d    = '0;
                        led_d    = IDLE_LEVEL;
                        rr_ptr_d = (sel_q == LastReq) ? '0 : sel_q + ReqW'(1);
                        state_d  = StGap;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        led_d     = pat_q[bit_idx_d];
                    end
                end
            end
            StGap: begin
                led_d = IDLE_LEVEL;
                if (step_tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                led_d   = IDLE_LEVEL;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            led_q     <= IDLE_LEVEL;
            pat_q     <= '0;
            bit_idx_q <= '0;
            rr_ptr_q  <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            led_q     <= led_d;
            pat_q     <= pat_d;
            bit_idx_q <= bit_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign LED  = led_q;

endmodule

// File: doc/led_pattern_arbiter.md
Name: led_pattern_arbiter

Overview:
- Shares the single user LED between NUM_REQ status sources. Each source presents a blink pattern and a request.
- A round-robin arbiter grants one source at a time. The block plays that source's latched pattern bit-serially on LED, one bit per step period, then releases the LED.
- Sits between the status producers (boot, USB, error, heartbeat) and the LED pin in the top level.
- Play is non-preemptive: once granted, a full pattern always plays.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PAT_W, 32, pattern length in bits; bit 0 plays first.
- STEP_DIV, 2097152, CLK cycles per pattern bit (2^21 at 16 MHz ≈ 131 ms).
- IDLE_LEVEL, 0, LED level when no pattern is playing.

Ports:
- CLK, in, 1, 16 MHz system clock.
- RST, in, 1, asynchronous active-high reset.
- req, in, NUM_REQ, per-source play request (level).
- pattern, in, NUM_REQ*PAT_W, per-source pattern; source i occupies bits [i*PAT_W +: PAT_W].
- gnt, out, NUM_REQ, one-hot grant; high for the whole play.
- done, out, NUM_REQ, one-cycle pulse to the granted source when its pattern completes.
- busy, out, 1, high in PLAY and GAP.
- LED, out, 1, registered LED drive.

Behaviour:
- Reset (RST high, asynchronous, any state):
  - state=IDLE; gnt=0; done=0; busy=0; LED=IDLE_LEVEL.
  - prescaler=0; bit_idx=0; rr_ptr=0.
  - A reset mid-play aborts the pattern immediately. No done pulse is issued.
- States: IDLE, PLAY, GAP.
- IDLE:
  - LED=IDLE_LEVEL.
  - If any req is high, select the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge: gnt[sel]=1, pattern[sel] latched into pat_q, bit_idx=0, prescaler=0, state=PLAY.
  - LED takes pat_q[0] on that same edge, so the first bit is visible 1 cycle after req is sampled.
- PLAY:
  - LED=pat_q[bit_idx], registered.
  - Prescaler counts 0..STEP_DIV-1. A tick occurs at the terminal count.
  - On a tick with bit_idx<PAT_W-1: bit_idx++, LED updates on the same edge.
  - Each bit is held exactly STEP_DIV cycles.
  - On a tick with bit_idx==PAT_W-1: done[sel] pulses for 1 cycle and gnt is cleared on that edge. Also on that edge: LED=IDLE_LEVEL, rr_ptr=(sel+1) mod NUM_REQ, state=GAP.
- GAP:
  - LED=IDLE_LEVEL for exactly STEP_DIV cycles, then state=IDLE.
  - Guarantees a visible separation between consecutive patterns.
- Total grant duration is PAT_W*STEP_DIV cycles. Source-to-source turnaround is STEP_DIV+1 cycles.
- Input changes during play:
  - req deasserted during PLAY is ignored; the pattern completes and done still pulses.
  - pattern changes after grant are ignored, because only pat_q is used.
- A source holding req continuously is re-granted only after every other requesting source has had one play (round-robin fairness).
- Simultaneous requests in IDLE: the rr_ptr order decides.
- After reset, rr_ptr=0, so index 0 wins.
- Prescaler width is clog2(STEP_DIV); bit_idx width is clog2(PAT_W). Both wrap explicitly via compare, never by overflow.
- STEP_DIV=1 is legal: one bit per cycle, and GAP lasts 1 cycle.
- gnt, done and busy are registered outputs with no combinational paths from inputs.

Decomposition:
- Package led_arb_pkg holds:
  - the state encoding (IDLE/PLAY/GAP);
  - the width localparams derived via clog2;
  - the round-robin select function (first set bit at or after the pointer, wrapping).
- Sub-module step_prescaler(CLK, RST, clr, tick):
  - a counter with synchronous clear and a terminal-count tick;
  - used for both PLAY and GAP timing.

Test Plan (sim params: NUM_REQ=4, PAT_W=8, STEP_DIV=4):
1. Reset, then req=4'b0001, pattern0=8'b1010_0011.
   - gnt=0001 one cycle later.
   - LED sequence is 1,1,0,0,0,1,0,1, each held 4 cycles.
   - done[0] pulses at cycle 33.
   - LED=0 for 4 GAP cycles.
2. req=4'b1111 held continuously.
   - Grants rotate 0→1→2→3→0.
   - Each grant lasts 32 cycles, with 5 cycles from done to the next gnt.
3. req0 pulsed for 1 cycle only.
   - The full 8-bit pattern still plays and done[0] still pulses.
   - pattern0 changed mid-play does not alter LED.
4. RST asserted mid-play at bit 3, asynchronously between edges.
   - LED=0, gnt=0 and busy=0 immediately.
   - No done pulse.
   - With req=4'b0110 after release, index 1 is granted first.
5. Idle check: req=0 for 100 cycles.
   - LED=IDLE_LEVEL, busy=0, gnt=0 throughout.
   - Rerun with IDLE_LEVEL=1: LED=1 in IDLE and GAP.
6. STEP_DIV=1 build, req=4'b1000, pattern3=8'hF0.
   - LED=0,0,0,0,1,1,1,1 on consecutive cycles.
   - done[3] pulses, then 1 GAP cycle.
